// File: rtl/io_handshake_port_pkg.sv
// rtl/io_handshake_port_pkg.sv - shared constants for the two-channel handshake port
//
// Contents:
//   DEF_WIDTH        default data width of both channels
//   FLAG_W           width of a channel's flag vector
//   FLAG_FULL        bit index of the full flag in a channel's flag vector
//   FLAG_OVR         bit index of the sticky overrun flag in a channel's flag vector
package io_handshake_port_pkg;

    localparam int DEF_WIDTH = 8;

    localparam int FLAG_W    = 2;
    localparam int FLAG_FULL = 0;
    localparam int FLAG_OVR  = 1;

endpackage

// File: rtl/io_handshake_port_hs_channel.sv
// rtl/io_handshake_port_hs_channel.sv - one-deep handshake channel with full and sticky overrun flags
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   wr_i, din_i    producer write strobe and data
//   ack_i          consumer has taken the data; clears full
//   ovr_clr_i      clears the overrun flag (a same-cycle overrun wins)
//   dout_o         data register contents
//   flags_o        {overrun, full} at FLAG_OVR / FLAG_FULL
//   full_next_o    next-state full flag, for registered interrupt logic upstream
module hs_channel
    import io_handshake_port_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_i,
    input  logic [WIDTH-1:0]  din_i,
    input  logic              ack_i,
    input  logic              ovr_clr_i,
    output logic [WIDTH-1:0]  dout_o,
    output logic [FLAG_W-1:0] flags_o,
    output logic              full_next_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;
    logic             ovr_q,  ovr_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        // Clear first so that an overrun in the same cycle re-sets the flag.
        ovr_d  = ovr_q & ~ovr_clr_i;
        if (wr_i) begin
            if (!full_q) begin
                data_d = din_i;
                full_d = 1'b1;
            end else if (ack_i) begin
                // Consumer drains and producer refills on the same edge.
                data_d = din_i;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (ack_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            full_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
            ovr_q  <= ovr_d;
        end
    end

    assign dout_o              = data_q;
    assign flags_o[FLAG_FULL]  = full_q;
    assign flags_o[FLAG_OVR]   = ovr_q;
    assign full_next_o         = rst_i ? 1'b0 : full_d;

endmodule

// File: rtl/io_handshake_port.sv
// rtl/io_handshake_port.sv - bidirectional two-register I/O port with full/empty handshake
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   a_in, a_wr               A side writes register R (A->B)
//   a_ack                    A has consumed S; clears fs
//   a_oe_, a_y               active-low enable and tristate output of S
//   b_in, b_wr               B side writes register S (B->A)
//   b_ack                    B has consumed R; clears fr
//   b_oe_, b_y               active-low enable and tristate output of R
//   fr, fs                   R full / S full
//   ovr_r, ovr_s             sticky overrun flags, cleared by ovr_clr
//   ien_a, irq_a_            interrupt enable and registered active-low interrupt to A
module io_handshake_port
    import io_handshake_port_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic             a_wr,
    input  logic             a_ack,
    input  logic             a_oe_,
    output logic [WIDTH-1:0] a_y,
    input  logic [WIDTH-1:0] b_in,
    input  logic             b_wr,
    input  logic             b_ack,
    input  logic             b_oe_,
    output logic [WIDTH-1:0] b_y,
    output logic             fr,
    output logic             fs,
    output logic             ovr_r,
    output logic             ovr_s,
    input  logic             ovr_clr,
    output logic             irq_a_,
    input  logic             ien_a
);

    logic [WIDTH-1:0]  r_data, s_data;
    logic [FLAG_W-1:0] r_flags, s_flags;
    logic              fr_next, fs_next;
    logic              irq_q;

    hs_channel #(.WIDTH(WIDTH)) u_chan_r (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_i        (a_wr),
        .din_i       (a_in),
        .ack_i       (b_ack),
        .ovr_clr_i   (ovr_clr),
        .dout_o      (r_data),
        .flags_o     (r_flags),
        .full_next_o (fr_next)
    );

    hs_channel #(.WIDTH(WIDTH)) u_chan_s (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_i        (b_wr),
        .din_i       (b_in),
        .ack_i       (a_ack),
        .ovr_clr_i   (ovr_clr),
        .dout_o      (s_data),
        .flags_o     (s_flags),
        .full_next_o (fs_next)
    );

    // Interrupt is computed from next-state flags so it lines up with fr/fs.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= ~ien_a;
        end else begin
            irq_q <= ~(ien_a & (fs_next | ~fr_next));
        end
    end

    assign fr     = r_flags[FLAG_FULL];
    assign fs     = s_flags[FLAG_FULL];
    assign ovr_r  = r_flags[FLAG_OVR];
    assign ovr_s  = s_flags[FLAG_OVR];
    assign irq_a_ = irq_q;

    assign a_y = a_oe_ ? {WIDTH{1'bz}} : s_data;
    assign b_y = b_oe_ ? {WIDTH{1'bz}} : r_data;

endmodule

// File: tb/tb_io_handshake_port.sv
// tb/tb_io_handshake_port.sv - scoreboard bench for io_handshake_port
module tb_io_handshake_port;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] a_in = '0;
    logic       a_wr = 1'b0;
    logic       a_ack = 1'b0;
    logic       a_oe_ = 1'b1;
    wire  [7:0] a_y;
    logic [7:0] b_in = '0;
    logic       b_wr = 1'b0;
    logic       b_ack = 1'b0;
    logic       b_oe_ = 1'b1;
    wire  [7:0] b_y;
    logic       fr, fs, ovr_r, ovr_s, irq_a_;
    logic       ovr_clr = 1'b0;
    logic       ien_a = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_handshake_port #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .a_in(a_in), .a_wr(a_wr), .a_ack(a_ack), .a_oe_(a_oe_), .a_y(a_y),
        .b_in(b_in), .b_wr(b_wr), .b_ack(b_ack), .b_oe_(b_oe_), .b_y(b_y),
        .fr(fr), .fs(fs), .ovr_r(ovr_r), .ovr_s(ovr_s), .ovr_clr(ovr_clr),
        .irq_a_(irq_a_), .ien_a(ien_a)
    );

    typedef struct {
        logic       fr, fs, ovr_r, ovr_s, irq_n;
        logic [7:0] ry, sy;
        logic       a_oe_n, b_oe_n;
    } exp_t;

    exp_t sb[$];

    // Reference model: each channel is a mailbox holding at most one item.
    logic [7:0] r_box[$];
    logic [7:0] s_box[$];
    logic [7:0] r_last = '0, s_last = '0;
    logic       m_ovr_r = 1'b0, m_ovr_s = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic aw, input logic [7:0] ai, input logic bk,
                        input logic bw, input logic [7:0] bi, input logic ak,
                        input logic oc, input logic ie, input logic aoe, input logic boe);
        exp_t e;
        @(negedge clk);
        rst = r; a_wr = aw; a_in = ai; b_ack = bk;
        b_wr = bw; b_in = bi; a_ack = ak; ovr_clr = oc; ien_a = ie;
        a_oe_ = aoe; b_oe_ = boe;
        if (r) begin
            r_box.delete(); s_box.delete();
            r_last = '0; s_last = '0;
            m_ovr_r = 1'b0; m_ovr_s = 1'b0;
        end else begin
            if (oc) begin
                m_ovr_r = 1'b0;
                m_ovr_s = 1'b0;
            end
            if (bk && r_box.size() > 0) void'(r_box.pop_front());
            if (ak && s_box.size() > 0) void'(s_box.pop_front());
            if (aw) begin
                if (r_box.size() == 0) begin r_box.push_back(ai); r_last = ai; end
                else m_ovr_r = 1'b1;
            end
            if (bw) begin
                if (s_box.size() == 0) begin s_box.push_back(bi); s_last = bi; end
                else m_ovr_s = 1'b1;
            end
        end
        e.fr     = (r_box.size() != 0);
        e.fs     = (s_box.size() != 0);
        e.ovr_r  = m_ovr_r;
        e.ovr_s  = m_ovr_s;
        e.irq_n  = !(ie && (e.fs || !e.fr));
        e.ry     = r_last;
        e.sy     = s_last;
        e.a_oe_n = aoe;
        e.b_oe_n = boe;
        sb.push_back(e);
    endtask

    task automatic idle(input logic ie);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, ie, 0, 0);
    endtask

    // Monitor: every edge the DUT presents its state; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("fr",     {7'd0, fr},     {7'd0, e.fr});
                check("fs",     {7'd0, fs},     {7'd0, e.fs});
                check("ovr_r",  {7'd0, ovr_r},  {7'd0, e.ovr_r});
                check("ovr_s",  {7'd0, ovr_s},  {7'd0, e.ovr_s});
                check("irq_a_", {7'd0, irq_a_}, {7'd0, e.irq_n});
                if (!e.b_oe_n) check("b_y", b_y, e.ry);
                if (!e.a_oe_n) check("a_y", a_y, e.sy);
            end
        end
    end

    initial begin
        // Reset with a write pending: write is ignored.
        step(1, 1, 8'hFF, 0, 1, 8'hEE, 0, 0, 0, 0, 0);
        step(1, 1, 8'hFF, 0, 0, 8'h00, 0, 0, 0, 1, 1);
        idle(0);
        // A->B transfer then consume.
        step(0, 1, 8'hA5, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        idle(0);
        step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        idle(0);
        // Overrun, clear, clear coincident with new overrun.
        step(0, 1, 8'h3C, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        step(0, 1, 8'hC3, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0);
        step(0, 1, 8'h99, 0, 0, 8'h00, 0, 1, 0, 0, 0);
        step(0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 0, 0);
        // Same-cycle refill.
        step(0, 1, 8'h11, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        step(0, 1, 8'h22, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        // B->A with interrupt.
        idle(1);
        step(0, 1, 8'h77, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        step(0, 0, 8'h00, 0, 1, 8'h5A, 0, 0, 1, 0, 0);
        step(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 0, 0);
        step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0, 0);
        // Concurrency, then reset mid-operation.
        step(0, 1, 8'h0F, 0, 1, 8'hF0, 0, 0, 1, 0, 0);
        step(0, 1, 8'h01, 0, 1, 8'h02, 0, 0, 1, 0, 0);
        step(1, 1, 8'h55, 0, 1, 8'hAA, 0, 0, 1, 0, 0);
        idle(1);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0),
                 $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1),
                 $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_handshake_port.md
Name: io_handshake_port

Overview:
- Two-register bidirectional data port between a processor side (A) and a peripheral side (B); Am2950-style I/O port with full/empty handshake flags.
- Channel R carries A->B, channel S carries B->A; each has a data register, a full flag and a sticky overrun flag.
- Data outputs are noninverting tristate, enabled by active-low enables, matching the bus-interface latch parts in the same library.

Parameters:
- WIDTH, 8, data width of both channels.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- a_in  in  WIDTH  A-side write data into R
- a_wr  in  1  A writes a_in into R
- a_ack  in  1  A has consumed S; clears fs
- a_oe_  in  1  active-low enable for a_y
- a_y  out  WIDTH  S register contents, tristate
- b_in  in  WIDTH  B-side write data into S
- b_wr  in  1  B writes b_in into S
- b_ack  in  1  B has consumed R; clears fr
- b_oe_  in  1  active-low enable for b_y
- b_y  out  WIDTH  R register contents, tristate
- fr  out  1  R full (data pending for B)
- fs  out  1  S full (data pending for A)
- ovr_r  out  1  sticky: A wrote while R full
- ovr_s  out  1  sticky: B wrote while S full
- ovr_clr  in  1  clears both overrun flags
- irq_a_  out  1  active-low; low when fs=1 or R empty with ien_a=1
- ien_a  in  1  interrupt enable for irq_a_

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high; rst has priority over every other input.
- Reset values: R=0, S=0, fr=0, fs=0, ovr_r=0, ovr_s=0, irq_a_=1 when ien_a=0.
- Outputs: a_y = a_oe_ ? Z : S; b_y = b_oe_ ? Z : R. Combinational on oe_ and independent of rst; they show 0 after reset when enabled.
- Channel R, evaluated per edge with rst=0:
  - a_wr=1, fr=0: R<=a_in, fr<=1.
  - a_wr=1, fr=1, b_ack=0: R unchanged, fr stays 1, ovr_r<=1 (data lost).
  - a_wr=1, fr=1, b_ack=1: R<=a_in, fr stays 1, no overrun (consume and refill in the same cycle).
  - a_wr=0, b_ack=1: fr<=0, R holds its value.
  - b_ack while fr=0: no effect.
- Channel S: identical rules with b_wr/b_in/a_ack/fs/ovr_s.
- Latency: new data and flag are visible on b_y/fr one edge after a_wr; no combinational path from a_in to b_y.
- Overrun: ovr_clr=1 clears both flags at the edge. If a new overrun occurs in the same cycle, set wins and the flag stays 1.
- Interrupt: irq_a_ = ~(ien_a & (fs | ~fr)), registered (updated at the edge from next-state flags). After reset with ien_a=1, irq_a_=0 (R empty).
- Channels are fully independent; simultaneous activity on R and S in one cycle is legal.
- Reset mid-handshake discards pending data and flags; a wr in the reset cycle is ignored.

Decomposition:
- Shared package: WIDTH default, and the channel flag encoding (FULL, OVR bit indices) used by both channel instances and by the bench.
- One sub-module, hs_channel (register, full flag, overrun flag, wr/ack rules), instantiated twice (R and S). The top adds the tristate drivers and the irq logic.

Test Plan:
- Reset: rst=1 with a_wr=1, a_in=8'hFF -> after the edge fr=0, b_y=8'h00 (b_oe_=0), ovr_r=0; with b_oe_=1 -> b_y=ZZZZZZZZ.
- A->B transfer: a_in=8'hA5, a_wr pulse -> next edge fr=1, b_y=8'hA5; b_ack pulse -> fr=0, b_y still 8'hA5.
- Overrun: R full with 8'h3C, a_wr with a_in=8'hC3 and b_ack=0 -> b_y=8'h3C, ovr_r=1; ovr_clr pulse -> ovr_r=0; ovr_clr coincident with a new overrun -> ovr_r=1.
- Same-cycle refill: R full with 8'h11, a_wr with a_in=8'h22 and b_ack=1 -> fr=1, b_y=8'h22, ovr_r=0.
- B->A plus irq: ien_a=1 and R empty -> irq_a_=0; fill R -> irq_a_=1; b_wr with b_in=8'h5A -> fs=1, a_y=8'h5A, irq_a_=0; a_ack -> fs=0.
- Concurrency/reset mid-operation: a_wr=8'h0F and b_wr=8'hF0 in the same cycle -> fr=fs=1 with correct data; then rst=1 -> all flags 0, R=S=0.
